wb_reg_bank: RTL and testbench

Parametrised Wishbone-style slave register bank. It is the successor to the fixed constant-ID register slave.
- Read-only constant ID words sit first, followed by read/write scratch/config words with byte enables.
- Programmable acknowledge latency; error response for bad accesses.
- Sits on the SoC peripheral bus at a configurable base address.

---
 rtl/wb_reg_bank_pkg.sv | 28 ++
 rtl/wb_reg_decode.sv | 30 +++
 rtl/wb_reg_bank.sv | 146 ++++++++++++++
 tb/tb_wb_reg_bank.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_reg_bank_pkg.sv
// Shared types and constants for the Wishbone register bank.
// Holds the read-only ID table and the transaction FSM encoding.
package wb_reg_bank_pkg;

    localparam int ADR_W  = 32;
    localparam int DAT_W  = 32;
    localparam int SEL_W  = 4;
    localparam int RO_MAX = 8;

    // ID words presented at the bottom of the bank; unused slots read as zero.
    localparam logic [DAT_W-1:0] RO_VALUES [RO_MAX] = '{
        32'h0001_0000,
        32'h0002_0000,
        32'h0003_0000,
        32'h0000_0000,
        32'h0000_0000,
        32'h0000_0000,
        32'h0000_0000,
        32'h0000_0000
    };

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/wb_reg_decode.sv
// Address decode for the register bank: word index, RO/RW region, and error flag.
// Purely combinational; fed from the latched request.
module wb_reg_decode
    import wb_reg_bank_pkg::*;
#(
    parameter logic [ADR_W-1:0] BASE_ADDR = 32'h0200_0100,
    parameter int               N_RO      = 3,
    parameter int               N_RW      = 4
) (
    input  logic [ADR_W-1:0] adr,
    input  logic             we,
    output logic [ADR_W-3:0] idx,
    output logic             is_ro,
    output logic             err
);

    localparam logic [ADR_W-3:0] RO_LIM    = (ADR_W-2)'(N_RO);
    localparam logic [ADR_W-3:0] WORDS_LIM = (ADR_W-2)'(N_RO + N_RW);

    logic [ADR_W-1:0] off;

    // Addresses below the base wrap to huge offsets and fall out of range.
    always_comb begin
        off   = adr - BASE_ADDR;
        idx   = off[ADR_W-1:2];
        is_ro = (idx < RO_LIM);
        err   = (off[1:0] != 2'b00) || (idx >= WORDS_LIM) || (we && is_ro);
    end

endmodule

// File: rtl/wb_reg_bank.sv
// Wishbone-style slave register bank: constant ID words followed by
// byte-writable scratch words, with a programmable acknowledge latency.
module wb_reg_bank
    import wb_reg_bank_pkg::*;
#(
    parameter logic [ADR_W-1:0] BASE_ADDR  = 32'h0200_0100,
    parameter int               N_RO       = 3,
    parameter int               N_RW       = 4,
    parameter int               ACK_LAT    = 1,
    parameter logic [DAT_W-1:0] RW_RST_VAL = 32'h0000_0000
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [ADR_W-1:0] iADR,
    input  logic [DAT_W-1:0] iDAT,
    input  logic [SEL_W-1:0] iSEL,
    input  logic             iWE,
    input  logic             iSTB,
    output logic [DAT_W-1:0] oDAT,
    output logic             oACK,
    output logic             oERR
);

    localparam int         RW_DEPTH = (N_RW > 0) ? N_RW : 1;
    localparam int         RW_AW    = (RW_DEPTH > 1) ? $clog2(RW_DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(ACK_LAT - 1);

    state_t           state_reg;
    logic [3:0]       cnt_reg;
    logic             stb_d_reg;
    logic [ADR_W-1:0] adr_reg;
    logic [DAT_W-1:0] dat_in_reg;
    logic [SEL_W-1:0] sel_reg;
    logic             we_reg;
    logic             ack_reg;
    logic             err_reg;
    logic [DAT_W-1:0] dat_out_reg;

    logic [ADR_W-3:0] idx;
    logic             is_ro;
    logic             dec_err;
    logic [ADR_W-3:0] rw_off;
    logic [RW_AW-1:0] rw_sel;
    logic [DAT_W-1:0] rw_rd_word;
    logic [DAT_W-1:0] rd_word;
    logic             resp_now;
    logic             wr_en;
    logic             unused_bits;

    wb_reg_decode #(
        .BASE_ADDR (BASE_ADDR),
        .N_RO      (N_RO),
        .N_RW      (N_RW)
    ) u_decode (
        .adr   (adr_reg),
        .we    (we_reg),
        .idx   (idx),
        .is_ro (is_ro),
        .err   (dec_err)
    );

    assign rw_off      = idx - (ADR_W-2)'(N_RO);
    assign rw_sel      = rw_off[RW_AW-1:0];
    assign resp_now    = (state_reg == WAIT) && (cnt_reg == 4'd0);
    assign wr_en       = resp_now && !dec_err && we_reg;
    assign rd_word     = is_ro ? RO_VALUES[idx[2:0]] : rw_rd_word;
    assign unused_bits = ^{idx[ADR_W-3:3], rw_off};

    // One byte-wide array per lane so each byte enable maps to its own storage.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_W; gi++) begin : g_lane
            logic [7:0] mem_reg [RW_DEPTH];

            always_ff @(posedge iCLK) begin
                if (iRST) begin
                    for (int w = 0; w < RW_DEPTH; w++) begin
                        mem_reg[w] <= RW_RST_VAL[8*gi +: 8];
                    end
                end else if (wr_en && sel_reg[gi]) begin
                    mem_reg[rw_sel] <= dat_in_reg[8*gi +: 8];
                end
            end

            assign rw_rd_word[8*gi +: 8] = mem_reg[rw_sel];
        end
    endgenerate

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            stb_d_reg   <= 1'b0;
            adr_reg     <= '0;
            dat_in_reg  <= '0;
            sel_reg     <= '0;
            we_reg      <= 1'b0;
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
            dat_out_reg <= '0;
        end else begin
            stb_d_reg <= iSTB;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (iSTB && !stb_d_reg) begin
                        adr_reg    <= iADR;
                        dat_in_reg <= iDAT;
                        sel_reg    <= iSEL;
                        we_reg     <= iWE;
                        cnt_reg    <= CNT_LOAD;
                        state_reg  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= RESP;
                        if (dec_err) begin
                            err_reg     <= 1'b1;
                            dat_out_reg <= '0;
                        end else begin
                            ack_reg <= 1'b1;
                            if (!we_reg) begin
                                dat_out_reg <= rd_word;
                            end
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign oDAT = dat_out_reg;
    assign oACK = ack_reg;
    assign oERR = err_reg;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Bench for wb_reg_bank: two instances (latency 1 and 4) on a shared bus,
// compared every cycle against a timestamp-based transaction model.
module tb_wb_reg_bank;

    localparam logic [31:0] BASE = 32'h0200_0100;
    localparam int NRO = 3;
    localparam int NRW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;

    logic [31:0] dat_a, dat_b;
    logic        ack_a, ack_b, err_a, err_b;

    wb_reg_bank #(.BASE_ADDR(BASE), .N_RO(NRO), .N_RW(NRW), .ACK_LAT(1), .RW_RST_VAL(32'h0)) dut_a (
        .iCLK(clk), .iRST(rst), .iADR(adr), .iDAT(wdat), .iSEL(sel), .iWE(we), .iSTB(stb),
        .oDAT(dat_a), .oACK(ack_a), .oERR(err_a)
    );

    wb_reg_bank #(.BASE_ADDR(BASE), .N_RO(NRO), .N_RW(NRW), .ACK_LAT(4), .RW_RST_VAL(32'h0)) dut_b (
        .iCLK(clk), .iRST(rst), .iADR(adr), .iDAT(wdat), .iSEL(sel), .iWE(we), .iSTB(stb),
        .oDAT(dat_b), .oACK(ack_b), .oERR(err_b)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int n_tx  = 0;
    int edge_n = 0;
    int t_edge = 0;
    bit live = 1'b0;

    // Model state, index 0 = latency-1 instance, index 1 = latency-4 instance
    logic [31:0] m_rw [2][NRW];
    bit          m_pend [2];
    int          m_due  [2];
    int          m_free [2];
    bit          m_stbd [2];
    logic [31:0] m_adr  [2];
    logic [31:0] m_wd   [2];
    logic [3:0]  m_sel  [2];
    bit          m_we   [2];
    logic [31:0] m_dat  [2];
    bit          m_ack  [2];
    bit          m_err  [2];

    int n_ack [2];
    int n_err [2];
    int resp_edge [2];

    function automatic logic [31:0] ro_word(input int i);
        case (i)
            0:       return 32'h0001_0000;
            1:       return 32'h0002_0000;
            2:       return 32'h0003_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h (edge %0d)", nm, got, exp, edge_n);
        end
    endtask

    task automatic model_step(input int d);
        logic [31:0] off;
        int          idx;
        if (rst) begin
            m_pend[d] = 1'b0;
            m_free[d] = 0;
            m_stbd[d] = 1'b0;
            m_ack[d]  = 1'b0;
            m_err[d]  = 1'b0;
            m_dat[d]  = '0;
            for (int w = 0; w < NRW; w++) m_rw[d][w] = 32'h0;
        end else begin
            m_ack[d] = 1'b0;
            m_err[d] = 1'b0;
            if (m_pend[d] && edge_n == m_due[d]) begin
                off = m_adr[d] - BASE;
                idx = int'(off >> 2);
                if (off[1:0] != 2'b00 || idx >= NRO + NRW || (m_we[d] && idx < NRO)) begin
                    m_err[d] = 1'b1;
                    m_dat[d] = '0;
                end else begin
                    m_ack[d] = 1'b1;
                    if (!m_we[d]) begin
                        m_dat[d] = (idx < NRO) ? ro_word(idx) : m_rw[d][idx-NRO];
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (m_sel[d][b]) m_rw[d][idx-NRO][8*b +: 8] = m_wd[d][8*b +: 8];
                    end
                end
                m_pend[d] = 1'b0;
                m_free[d] = edge_n + 2;
            end else if (!m_pend[d] && edge_n >= m_free[d] && stb && !m_stbd[d]) begin
                m_adr[d]  = adr;
                m_wd[d]   = wdat;
                m_sel[d]  = sel;
                m_we[d]   = we;
                m_pend[d] = 1'b1;
                m_due[d]  = edge_n + ((d == 0) ? 1 : 4);
            end
            m_stbd[d] = stb;
        end
    endtask

    always @(posedge clk) begin
        edge_n++;
        model_step(0);
        model_step(1);
        live = 1'b1;
    end

    always @(negedge clk) begin
        if (live) begin
            check("ackA", 32'(ack_a), 32'(m_ack[0]));
            check("errA", 32'(err_a), 32'(m_err[0]));
            check("datA", dat_a, m_dat[0]);
            check("ackB", 32'(ack_b), 32'(m_ack[1]));
            check("errB", 32'(err_b), 32'(m_err[1]));
            check("datB", dat_b, m_dat[1]);
            if (ack_a) n_ack[0]++;
            if (err_a) n_err[0]++;
            if (ack_a || err_a) resp_edge[0] = edge_n;
            if (ack_b) n_ack[1]++;
            if (err_b) n_err[1]++;
            if (ack_b || err_b) resp_edge[1] = edge_n;
        end
    end

    task automatic clr();
        for (int d = 0; d < 2; d++) begin
            n_ack[d] = 0;
            n_err[d] = 0;
            resp_edge[d] = -100;
        end
    endtask

    task automatic tx(input logic [31:0] a, input logic [31:0] dv, input logic [3:0] s,
                      input bit w, input int hold, input int idle);
        @(posedge clk);
        #1;
        adr = a; wdat = dv; sel = s; we = w; stb = 1'b1;
        t_edge = edge_n + 1;
        repeat (hold) @(posedge clk);
        #1 stb = 1'b0;
        repeat (idle) @(posedge clk);
        n_tx++;
        $display("tx %0d adr=%08h we=%0d sel=%h dat=%08h hold=%0d", n_tx, a, w, s, dv, hold);
    endtask

    // Directed transaction with literal expectations on both instances
    task automatic dtx(input string nm, input logic [31:0] a, input logic [31:0] dv, input logic [3:0] s,
                       input bit w, input int hold, input bit exp_err, input logic [31:0] exp_dat);
        clr();
        tx(a, dv, s, w, hold, 10);
        check({nm, "_ackcntA"}, 32'(n_ack[0]), exp_err ? 32'd0 : 32'd1);
        check({nm, "_errcntA"}, 32'(n_err[0]), exp_err ? 32'd1 : 32'd0);
        check({nm, "_ackcntB"}, 32'(n_ack[1]), exp_err ? 32'd0 : 32'd1);
        check({nm, "_errcntB"}, 32'(n_err[1]), exp_err ? 32'd1 : 32'd0);
        check({nm, "_latA"}, 32'(resp_edge[0] - t_edge), 32'd1);
        check({nm, "_latB"}, 32'(resp_edge[1] - t_edge), 32'd4);
        check({nm, "_datA"}, dat_a, exp_dat);
        check({nm, "_datB"}, dat_b, exp_dat);
    endtask

    initial begin
        logic [31:0] a;
        int          k;

        clr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_datA", dat_a, 32'h0);
        check("rst_ackA", 32'(ack_a), 32'h0);
        check("rst_errA", 32'(err_a), 32'h0);
        check("rst_datB", dat_b, 32'h0);
        check("rst_ackB", 32'(ack_b), 32'h0);
        check("rst_errB", 32'(err_b), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        dtx("rd_id0", 32'h0200_0100, 32'h0, 4'h0, 1'b0, 1, 1'b0, 32'h0001_0000);
        dtx("rd_id1", 32'h0200_0104, 32'h0, 4'h0, 1'b0, 1, 1'b0, 32'h0002_0000);
        dtx("rd_id2", 32'h0200_0108, 32'h0, 4'h0, 1'b0, 1, 1'b0, 32'h0003_0000);
        dtx("wr_rw0", 32'h0200_010C, 32'hDEAD_BEEF, 4'b0101, 1'b1, 1, 1'b0, 32'h0003_0000);
        dtx("rd_rw0", 32'h0200_010C, 32'h0, 4'h0, 1'b0, 1, 1'b0, 32'h00AD_00EF);
        dtx("wr_ro1", 32'h0200_0104, 32'h1234_5678, 4'hF, 1'b1, 1, 1'b1, 32'h0);
        dtx("rd_ro1", 32'h0200_0104, 32'h0, 4'h0, 1'b0, 1, 1'b0, 32'h0002_0000);
        dtx("rd_oor", 32'h0200_011C, 32'h0, 4'h0, 1'b0, 1, 1'b1, 32'h0);
        dtx("rd_top", 32'h0200_0118, 32'h0, 4'h0, 1'b0, 1, 1'b0, 32'h0);
        dtx("rd_mis", 32'h0200_0102, 32'h0, 4'h0, 1'b0, 1, 1'b1, 32'h0);
        dtx("rd_blw", 32'h0200_00FC, 32'h0, 4'h0, 1'b0, 1, 1'b1, 32'h0);
        dtx("rd_hold", 32'h0200_0100, 32'h0, 4'h0, 1'b0, 6, 1'b0, 32'h0001_0000);
        dtx("wr_rw3", 32'h0200_0118, 32'hCAFE_F00D, 4'b1010, 1'b1, 1, 1'b0, 32'h0001_0000);
        dtx("rd_rw3", 32'h0200_0118, 32'h0, 4'h0, 1'b0, 1, 1'b0, 32'hCA00_F000);

        // Reset lands while the latency-4 instance is still waiting
        clr();
        @(posedge clk);
        #1;
        adr = 32'h0200_0110; wdat = 32'hFFFF_FFFF; sel = 4'hF; we = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1 stb = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        n_tx++;
        $display("tx %0d adr=%08h we=1 with reset during wait", n_tx, 32'h0200_0110);
        check("rstwr_ackA", 32'(n_ack[0]), 32'd1);
        check("rstwr_ackB", 32'(n_ack[1]), 32'd0);
        check("rstwr_errB", 32'(n_err[1]), 32'd0);
        check("rstwr_datA", dat_a, 32'h0);
        check("rstwr_datB", dat_b, 32'h0);
        dtx("rd_after_rst", 32'h0200_0110, 32'h0, 4'h0, 1'b0, 1, 1'b0, 32'h0);
        dtx("rd_rw0_rst", 32'h0200_010C, 32'h0, 4'h0, 1'b0, 1, 1'b0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            k = int'($urandom_range(0, 11)) - 2;
            a = BASE + 32'(k * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            tx(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               int'($urandom_range(1, 3)), int'($urandom_range(0, 7)));
        end

        repeat (12) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
